scan_7seg_ctrl: RTL and testbench
=================================

SCAN_7SEG_CTRL -- requirements
Module: scan_7seg_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000, clock cycles each digit is lit (ON phase); legal range 2..2^20.
REQ-002 SHALL have parameter GUARD, default 4, clock cycles all anodes are off between digits (anti-ghosting); legal range 1..255.
REQ-003 SHALL have port i_Clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port i_Rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_Valor  input  16  four hex digits; digit k = i_Valor[4k+3:4k], digit 0 rightmost.
REQ-006 SHALL have port i_Cargar  input  1  load strobe; samples i_Valor on the same edge.
REQ-007 SHALL have port i_Habilitar  input  1  scan enable; low = display dark.
REQ-008 SHALL have port i_Blank_ceros  input  1  leading-zero blanking enable.
REQ-009 SHALL have port o_Bits  output  4  nibble for the shared 4-bit-to-7-segment decoder.
REQ-010 SHALL have port o_Anodos  output  4  digit selects, active-low, at most one low at any time.
REQ-011 SHALL have port o_Blank  output  1  high = segments forced off downstream.
REQ-012 SHALL have port o_Ocupado  output  1  high while a loaded value awaits the next frame start.
REQ-013 SHALL have port o_Listo  output  1  one-cycle pulse when a pending value becomes displayed.

Function
REQ-014 SHALL register every output; no combinational input-to-output path.
REQ-015 SHALL implement states APAGADO (dark), GUARDA (all anodes off), ENCENDIDO (one digit lit).
REQ-016 APAGADO -> GUARDA on first edge with i_Habilitar=1; digit index set so next lit digit is 0.
REQ-017 GUARDA lasts exactly GUARD cycles, then -> ENCENDIDO with digit index advanced by 1 modulo 4 (3 wraps to 0).
REQ-018 ENCENDIDO lasts exactly CLK_DIV cycles, then -> GUARDA; full frame = 4*(CLK_DIV+GUARD) cycles.
REQ-019 Any state -> APAGADO on the edge after i_Habilitar=0 is sampled; o_Anodos=4'b1111, o_Blank=1 from that cycle.
REQ-020 In ENCENDIDO for digit k: o_Anodos bit k=0, others 1; o_Bits = displayed-register nibble k; o_Blank=0, unless digit blanked.
REQ-021 In GUARDA and APAGADO: o_Anodos=4'b1111, o_Blank=1, o_Bits holds last value.
REQ-022 Leading-zero blanking: with i_Blank_ceros=1, digit k in 1..3 is blanked when nibbles k..3 of the displayed register are all zero; digit 0 never blanked.
REQ-023 Blanked digit: ENCENDIDO timing unchanged, o_Anodos=4'b1111, o_Blank=1.
REQ-024 i_Cargar=1 copies i_Valor into pending register and sets o_Ocupado=1 next cycle; repeated loads overwrite (last wins).
REQ-025 Frame start = GUARDA -> ENCENDIDO transition into digit 0; if o_Ocupado=1, pending copies to displayed register on that edge, o_Ocupado clears, o_Listo pulses one cycle.
REQ-026 i_Cargar coincident with frame start: i_Valor goes directly to displayed register, o_Listo pulses, o_Ocupado=0.
REQ-027 Display register never changes mid-frame; loads while in APAGADO stay pending until scanning resumes.
REQ-028 Counter sized for CLK_DIV; counter resets to 0 on every state entry.

Reset
REQ-029 On i_Rst_n=0, immediately (asynchronously): state APAGADO, digit index 3, counter 0, displayed and pending registers 16'h0000.
REQ-030 Reset outputs: o_Anodos=4'b1111, o_Bits=4'h0, o_Blank=1, o_Ocupado=0, o_Listo=0.
REQ-031 Reset mid-frame or mid-pending load discards pending value; after release, first edge with i_Habilitar=1 starts REQ-016 sequence.

Verification (CLK_DIV=4, GUARD=2)
REQ-032 Reset release, i_Habilitar=1, load 16'h1234 -> o_Ocupado=1 until frame start; then digits 0..3 show o_Bits 4,3,2,1 with o_Anodos 1110,1101,1011,0111, each 4 cycles, 2 dark cycles between.
REQ-033 i_Blank_ceros=1, load 16'h0050 -> digits 3,2 dark with o_Blank=1; digit 1 shows 5, digit 0 shows 0; load 16'h0000 -> only digit 0 lit showing 0.
REQ-034 Two loads mid-frame (16'hAAAA then 16'hBBBB) -> next frame shows B on all digits, exactly one o_Listo pulse.
REQ-035 i_Cargar on exact frame-start edge with 16'hC0DE -> digit 0 shows E that frame, o_Ocupado never asserted.
REQ-036 i_Habilitar dropped mid-digit 2 -> o_Anodos=4'b1111 next cycle; re-enable -> scan restarts at digit 0 after GUARD cycles.
REQ-037 i_Rst_n pulsed low mid-ENCENDIDO with pending load -> outputs to reset values same cycle, pending lost, displayed 16'h0000.

Source files
------------

// File: rtl/scan_7seg_ctrl.sv
// Multiplexed 4-digit 7-segment scan controller: one digit lit at a time with
// dark guard gaps, double-buffered value updated only at frame start, leading-zero blanking.
module scan_7seg_ctrl #(
  parameter int CLK_DIV = 50000,
  parameter int GUARD   = 4
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic [15:0] i_Valor,
  input  logic        i_Cargar,
  input  logic        i_Habilitar,
  input  logic        i_Blank_ceros,
  output logic [3:0]  o_Bits,
  output logic [3:0]  o_Anodos,
  output logic        o_Blank,
  output logic        o_Ocupado,
  output logic        o_Listo
);

  // state     | meaning
  // APAGADO   | scanning disabled, display dark
  // GUARDA    | all anodes off between digits
  // ENCENDIDO | digit digit_q lit for CLK_DIV cycles
  typedef enum logic [1:0] {APAGADO, GUARDA, ENCENDIDO} state_t;

  localparam int CW = ($clog2(CLK_DIV) > 8) ? $clog2(CLK_DIV) : 8;
  localparam logic [CW-1:0] ON_LAST    = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);

  state_t        state_q, state_d;
  logic [1:0]    digit_q, digit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   disp_q, disp_d;
  logic [15:0]   pend_q, pend_d;
  logic          ocup_q, ocup_d;
  logic          listo_q, listo_d;
  logic [3:0]    anod_q, anod_d;
  logic [3:0]    bits_q, bits_d;
  logic          blank_q, blank_d;
  logic          frame_start;
  logic          lead_zero;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= APAGADO;
      digit_q <= 2'd3;
      cnt_q   <= '0;
      disp_q  <= 16'h0000;
      pend_q  <= 16'h0000;
      ocup_q  <= 1'b0;
      listo_q <= 1'b0;
      anod_q  <= 4'b1111;
      bits_q  <= 4'h0;
      blank_q <= 1'b1;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      pend_q  <= pend_d;
      ocup_q  <= ocup_d;
      listo_q <= listo_d;
      anod_q  <= anod_d;
      bits_q  <= bits_d;
      blank_q <= blank_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    digit_d     = digit_q;
    cnt_d       = cnt_q + CW'(1);
    disp_d      = disp_q;
    pend_d      = pend_q;
    ocup_d      = ocup_q;
    listo_d     = 1'b0;
    frame_start = 1'b0;

    if (i_Cargar) begin
      pend_d = i_Valor;
      ocup_d = 1'b1;
    end

    if (!i_Habilitar) begin
      state_d = APAGADO;
      cnt_d   = '0;
    end else begin
      case (state_q)
        APAGADO: begin
          state_d = GUARDA;
          digit_d = 2'd3;
          cnt_d   = '0;
        end
        GUARDA: begin
          if (cnt_q == GUARD_LAST) begin
            state_d     = ENCENDIDO;
            digit_d     = digit_q + 2'd1;
            cnt_d       = '0;
            frame_start = (digit_q == 2'd3);
          end
        end
        ENCENDIDO: begin
          if (cnt_q == ON_LAST) begin
            state_d = GUARDA;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = APAGADO;
          cnt_d   = '0;
        end
      endcase
    end

    // A load on the frame-start edge bypasses the pending buffer entirely.
    if (frame_start) begin
      if (i_Cargar) begin
        disp_d  = i_Valor;
        ocup_d  = 1'b0;
        listo_d = 1'b1;
      end else if (ocup_q) begin
        disp_d  = pend_q;
        ocup_d  = 1'b0;
        listo_d = 1'b1;
      end
    end
  end

  // Outputs are derived from next-state values so they line up with the state.
  always_comb begin
    case (digit_d)
      2'd1:    lead_zero = (disp_d[15:4] == 12'h000);
      2'd2:    lead_zero = (disp_d[15:8] == 8'h00);
      2'd3:    lead_zero = (disp_d[15:12] == 4'h0);
      default: lead_zero = 1'b0;
    endcase

    anod_d  = 4'b1111;
    blank_d = 1'b1;
    bits_d  = bits_q;
    if (state_d == ENCENDIDO) begin
      bits_d = disp_d[{digit_d, 2'b00} +: 4];
      if (!(i_Blank_ceros && lead_zero)) begin
        anod_d  = ~(4'b0001 << digit_d);
        blank_d = 1'b0;
      end
    end
  end

  assign o_Bits    = bits_q;
  assign o_Anodos  = anod_q;
  assign o_Blank   = blank_q;
  assign o_Ocupado = ocup_q;
  assign o_Listo   = listo_q;

endmodule

// File: tb/tb_scan_7seg_ctrl.sv
// Scoreboard bench for scan_7seg_ctrl: a frame-arithmetic reference model queues
// expected lit-digit / o_Listo events; a monitor pops them when the DUT shows one.
module tb_scan_7seg_ctrl;
  localparam int CLK_DIV = 4;
  localparam int GUARD   = 2;
  localparam int SLOT    = CLK_DIV + GUARD;
  localparam int FRAME   = 4 * SLOT;

  logic        i_Clk = 1'b0;
  logic        i_Rst_n;
  logic [15:0] i_Valor = 16'h0;
  logic        i_Cargar = 1'b0;
  logic        i_Habilitar = 1'b0;
  logic        i_Blank_ceros = 1'b0;
  logic [3:0]  o_Bits;
  logic [3:0]  o_Anodos;
  logic        o_Blank;
  logic        o_Ocupado;
  logic        o_Listo;

  always #5 i_Clk = ~i_Clk;

  scan_7seg_ctrl #(.CLK_DIV(CLK_DIV), .GUARD(GUARD)) dut (
    .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_Valor(i_Valor), .i_Cargar(i_Cargar),
    .i_Habilitar(i_Habilitar), .i_Blank_ceros(i_Blank_ceros), .o_Bits(o_Bits),
    .o_Anodos(o_Anodos), .o_Blank(o_Blank), .o_Ocupado(o_Ocupado), .o_Listo(o_Listo)
  );

  typedef struct {
    int       stamp;
    logic [3:0] anod;
    logic [3:0] bits;
    logic     listo;
  } ev_t;

  ev_t exp_q[$];
  ev_t ev;
  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;

  // Reference model: position inside the scan is plain arithmetic on the number
  // of edges since scanning started.
  bit          m_en;
  int          m_n;
  int          m_k;
  logic [15:0] m_disp, m_pend;
  bit          m_ocup, m_listo, m_lit, m_lz, m_bits_known;
  logic [3:0]  m_nib, m_last_bits;

  always @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      m_en = 0; m_n = 0; m_disp = 16'h0; m_pend = 16'h0; m_ocup = 0;
      m_last_bits = 4'h0; m_bits_known = 1;
      exp_q.delete();
    end else begin
      m_listo = 0;
      if (!i_Habilitar) begin
        m_en = 0;
        if (i_Cargar) begin m_pend = i_Valor; m_ocup = 1; end
      end else if (!m_en) begin
        m_en = 1;
        m_n = 0;
        if (i_Cargar) begin m_pend = i_Valor; m_ocup = 1; end
      end else begin
        m_n++;
        if ((m_n % FRAME) == GUARD && (i_Cargar || m_ocup)) begin
          m_disp = i_Cargar ? i_Valor : m_pend;
          m_ocup = 0;
          m_listo = 1;
        end else if (i_Cargar) begin
          m_pend = i_Valor;
          m_ocup = 1;
        end
      end
      m_lit = 0;
      m_k = 0;
      m_nib = m_last_bits;
      if (m_en && (m_n % SLOT) >= GUARD) begin
        m_k = (m_n / SLOT) % 4;
        m_nib = 4'((m_disp >> (4 * m_k)) & 16'hF);
        m_lz = i_Blank_ceros && (m_k > 0) && ((m_disp >> (4 * m_k)) == 16'h0);
        if (m_lz) m_bits_known = 0;
        else begin
          m_lit = 1;
          m_last_bits = m_nib;
          m_bits_known = 1;
        end
      end
      if (m_lit || m_listo)
        exp_q.push_back('{cyc, m_lit ? 4'(~(4'b0001 << m_k)) : 4'hF, m_nib, m_listo});
    end
  end

  always @(negedge i_Clk) begin
    while (exp_q.size() > 0 && exp_q[0].stamp < cyc) begin
      checks++; errors++;
      $display("FAIL missed_event cycle=%0d actual=none required anod=%b bits=%h listo=%0b",
               exp_q[0].stamp, exp_q[0].anod, exp_q[0].bits, exp_q[0].listo);
      void'(exp_q.pop_front());
    end
    if (o_Anodos != 4'b1111 || o_Listo) begin
      checks++;
      if (exp_q.size() == 0 || exp_q[0].stamp != cyc) begin
        errors++;
        $display("FAIL unexpected_event cycle=%0d actual anod=%b bits=%h listo=%0b required=no event",
                 cyc, o_Anodos, o_Bits, o_Listo);
      end else begin
        ev = exp_q.pop_front();
        if (o_Anodos !== ev.anod || o_Bits !== ev.bits || o_Listo !== ev.listo || o_Blank !== 1'b0) begin
          errors++;
          $display("FAIL event cycle=%0d actual anod=%b bits=%h listo=%0b blank=%0b required anod=%b bits=%h listo=%0b blank=0",
                   cyc, o_Anodos, o_Bits, o_Listo, o_Blank, ev.anod, ev.bits, ev.listo);
        end
      end
    end else begin
      checks++;
      if (o_Blank !== 1'b1) begin
        errors++;
        $display("FAIL dark_blank cycle=%0d actual=%0b required=1", cyc, o_Blank);
      end
      if (m_bits_known) begin
        checks++;
        if (o_Bits !== m_last_bits) begin
          errors++;
          $display("FAIL bits_hold cycle=%0d actual=%h required=%h", cyc, o_Bits, m_last_bits);
        end
      end
    end
    checks++;
    if (o_Ocupado !== m_ocup) begin
      errors++;
      $display("FAIL ocupado cycle=%0d actual=%0b required=%0b", cyc, o_Ocupado, m_ocup);
    end
    cyc++;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge i_Clk);
  endtask

  task automatic load(input logic [15:0] v);
    i_Valor = v;
    i_Cargar = 1'b1;
    tick(1);
    i_Cargar = 1'b0;
  endtask

  task automatic wait_pos(input int r);
    for (int b = 0; b < 4 * FRAME; b++) begin
      if (m_en && (m_n % FRAME) == r) return;
      tick(1);
    end
    checks++; errors++;
    $display("FAIL wait_pos_timeout actual=not reached required=frame position %0d", r);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_anodos"}, 16'(o_Anodos), 16'hF);
    chk({tag, "_bits"}, 16'(o_Bits), 16'h0);
    chk({tag, "_blank"}, 16'(o_Blank), 16'h1);
    chk({tag, "_ocupado"}, 16'(o_Ocupado), 16'h0);
    chk({tag, "_listo"}, 16'(o_Listo), 16'h0);
  endtask

  initial begin
    i_Rst_n = 1'b1;
    #1 i_Rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    tick(3);
    i_Rst_n = 1'b1;
    tick(2);

    // 1234 loaded as scanning starts: pending until the first frame start
    i_Habilitar = 1'b1;
    load(16'h1234);
    tick(2 * FRAME);

    // leading-zero blanking
    i_Blank_ceros = 1'b1;
    load(16'h0050);
    tick(2 * FRAME);
    load(16'h0000);
    tick(2 * FRAME);
    i_Blank_ceros = 1'b0;

    // two loads inside one frame: last wins, one o_Listo
    wait_pos(8);
    load(16'hAAAA);
    tick(3);
    load(16'hBBBB);
    tick(2 * FRAME);

    // load exactly on the frame-start edge
    wait_pos(GUARD - 1);
    load(16'hC0DE);
    tick(2 * FRAME);

    // disable in the middle of digit 2, load while dark, re-enable
    wait_pos(2 * SLOT + GUARD + 1);
    i_Habilitar = 1'b0;
    tick(1);
    chk("anodos_after_disable", 16'(o_Anodos), 16'hF);
    load(16'h9876);
    tick(3);
    i_Habilitar = 1'b1;
    tick(2 * FRAME);

    // asynchronous reset while a digit is lit and a load is pending
    wait_pos(SLOT + GUARD + 1);
    load(16'h5A5A);
    @(posedge i_Clk);
    #3 i_Rst_n = 1'b0;
    #1 check_reset_outputs("midframe_reset");
    @(negedge i_Clk);
    i_Rst_n = 1'b1;
    tick(2 * FRAME);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic [15:0] v;
      for (int j = 0; j < 4; j++)
        v[4*j +: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
      i_Valor = v;
      i_Cargar = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 39) == 0) i_Blank_ceros = ~i_Blank_ceros;
      i_Habilitar = ($urandom_range(0, 79) != 0);
      tick(1);
    end
    i_Cargar = 1'b0;
    i_Habilitar = 1'b1;
    tick(FRAME);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_events actual=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
